// File: rtl/pwm_pkg.sv
// Shared types and defaults for the high-resolution PWM capture block.
package pwm_pkg;

    localparam int WIDTH_DEF  = 17;
    localparam int HRBITS_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] period;
        logic [WIDTH_DEF-1:0] highTime;
    } cap_result_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Result channel of pwm_capture: valid/ready handshake carrying period and high time.
interface pwm_capture_if import pwm_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             capValid;
    logic             capReady;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] highTime;

    modport master (output capValid, output period, output highTime, input capReady);
    modport slave  (input capValid, input period, input highTime, output capReady);

endinterface

// File: rtl/pwm_capture_hr_edge_find.sv
// Finds the lowest edge of one polarity at or after a start index in a sample word.
module hr_edge_find import pwm_pkg::*; #(
    parameter int HRBITS = HRBITS_DEF
) (
    input  logic [(1 << HRBITS):0] word,
    input  logic                   rise,
    input  logic [HRBITS:0]        start,
    output logic                   found,
    output logic [HRBITS-1:0]      index
);

    localparam int N = 1 << HRBITS;

    logic [N-1:0] hit_s;
    logic [N-1:0] cand_s;

    // edge at sample index k compares word bit k (older) with word bit k+1
    always_comb begin
        hit_s = '0;
        if (rise) begin
            hit_s = ~word[N-1:0] & word[N:1];
        end else begin
            hit_s = word[N-1:0] & ~word[N:1];
        end
    end

    assign cand_s = hit_s & ({N{1'b1}} << start);
    assign found  = |cand_s;

    // scan downward so the lowest qualifying index is the one left standing
    always_comb begin
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            index = cand_s[k] ? HRBITS'(k) : index;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// High-resolution PWM period / high-time capture from deserialized pin samples.
module pwm_capture import pwm_pkg::*; #(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HRBITS = HRBITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-HRBITS-1:0]  tb,
    input  logic [(1 << HRBITS)-1:0] pinD,
    output logic [2:0]               flags,
    input  logic                     clrFlags,
    pwm_capture_if.master            cap
);

    localparam int N   = 1 << HRBITS;
    localparam int TBW = WIDTH - HRBITS;
    localparam int SW  = HRBITS + 1;
    localparam logic [TBW-1:0] STUCK_MAX = {TBW{1'b1}};

    pwm_state_t       state_r;
    logic             prev_msb_r;
    logic [WIDTH-1:0] rise_ts_r;
    logic [WIDTH-1:0] fall_ts_r;
    logic [TBW-1:0]   stuck_cnt_r;
    logic             cap_valid_r;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] high_time_r;
    logic [2:0]       flags_r;

    logic [N:0]        word_s;
    logic              first_rise_s;
    logic              found1_s;
    logic              found2_raw_s;
    logic              found2_s;
    logic [HRBITS-1:0] idx1_s;
    logic [HRBITS-1:0] idx2_s;
    logic [SW-1:0]     start2_s;
    logic [SW-1:0]     start3_s;
    logic [WIDTH-1:0]  ts1_s;
    logic [WIDTH-1:0]  ts2_s;
    logic [N-1:0]      edges_s;
    logic              glitch_s;
    logic              done_s;
    logic [WIDTH-1:0]  res_period_s;
    logic [WIDTH-1:0]  res_high_s;
    logic [TBW-1:0]    stuck_inc_s;
    logic              stuck_s;
    logic              accept_s;
    logic              overrun_s;

    assign word_s       = {pinD, prev_msb_r};
    assign first_rise_s = (state_r != HIGH);
    assign start2_s     = {1'b0, idx1_s} + SW'(1);
    assign start3_s     = {1'b0, idx2_s} + SW'(1);
    assign ts1_s        = {tb, idx1_s};
    assign ts2_s        = {tb, idx2_s};
    assign found2_s     = found1_s & found2_raw_s;

    hr_edge_find #(.HRBITS(HRBITS)) u_first_edge (
        .word  (word_s),
        .rise  (first_rise_s),
        .start ({SW{1'b0}}),
        .found (found1_s),
        .index (idx1_s)
    );

    hr_edge_find #(.HRBITS(HRBITS)) u_next_edge (
        .word  (word_s),
        .rise  (~first_rise_s),
        .start (start2_s),
        .found (found2_raw_s),
        .index (idx2_s)
    );

    // anything left after the second consumed edge is a glitch
    assign edges_s  = word_s[N-1:0] ^ word_s[N:1];
    assign glitch_s = found2_s & (|(edges_s & ({N{1'b1}} << start3_s)));

    // a result completes whenever a rise closes a rise-fall-rise sequence
    always_comb begin
        done_s       = 1'b0;
        res_period_s = '0;
        res_high_s   = '0;
        case (state_r)
            HIGH: begin
                if (found2_s) begin
                    done_s       = 1'b1;
                    res_period_s = ts2_s - rise_ts_r;
                    res_high_s   = ts1_s - rise_ts_r;
                end else begin
                    done_s = 1'b0;
                end
            end
            LOW: begin
                if (found1_s) begin
                    done_s       = 1'b1;
                    res_period_s = ts1_s - rise_ts_r;
                    res_high_s   = fall_ts_r - rise_ts_r;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: done_s = 1'b0;
        endcase
    end

    assign stuck_inc_s = stuck_cnt_r + TBW'(1);
    assign stuck_s     = ~found1_s & (stuck_inc_s == STUCK_MAX);
    assign accept_s    = done_s & ~(cap_valid_r & ~cap.capReady);
    assign overrun_s   = done_s & cap_valid_r & ~cap.capReady;

    // measurement FSM: up to two transitions per word, stuck watchdog forces IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            prev_msb_r  <= 1'b1;
            rise_ts_r   <= '0;
            fall_ts_r   <= '0;
            stuck_cnt_r <= '0;
        end else begin
            prev_msb_r <= pinD[N-1];
            if (stuck_s) begin
                state_r     <= IDLE;
                stuck_cnt_r <= '0;
            end else begin
                stuck_cnt_r <= found1_s ? '0 : stuck_inc_s;
                case (state_r)
                    IDLE, LOW: begin
                        if (found1_s) begin
                            rise_ts_r <= ts1_s;
                            if (found2_s) begin
                                fall_ts_r <= ts2_s;
                                state_r   <= LOW;
                            end else begin
                                state_r <= HIGH;
                            end
                        end
                    end
                    HIGH: begin
                        if (found1_s) begin
                            fall_ts_r <= ts1_s;
                            if (found2_s) begin
                                rise_ts_r <= ts2_s;
                                state_r   <= HIGH;
                            end else begin
                                state_r <= LOW;
                            end
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    // result register with valid/ready hold, plus sticky flags where set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_r <= 1'b0;
            period_r    <= '0;
            high_time_r <= '0;
            flags_r     <= 3'b000;
        end else begin
            if (accept_s) begin
                cap_valid_r <= 1'b1;
                period_r    <= res_period_s;
                high_time_r <= res_high_s;
            end else if (cap_valid_r && cap.capReady) begin
                cap_valid_r <= 1'b0;
            end
            flags_r <= {stuck_s, overrun_s, glitch_s} | (flags_r & {3{~clrFlags}});
        end
    end

    assign cap.capValid = cap_valid_r;
    assign cap.period   = period_r;
    assign cap.highTime = high_time_r;
    assign flags        = flags_r;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 17, the full timestamp width in high-res LSBs.
REQ-002 The block SHALL have parameter HRBITS, default 3, sub-phase bits per timebase tick; the word width is N = 1<<HRBITS.
REQ-003 The block SHALL have port clk  input  1  the single clock.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port tb  input  WIDTH-HRBITS  the free-running timebase, +1 per clk, wrapping.
REQ-006 The block SHALL have port pinD  input  N  the deserialized input samples for the current tb tick; bit 0 is the earliest.
REQ-007 The block SHALL have port capValid  output  1  a measurement result is held.
REQ-008 The block SHALL have port capReady  input  1  the consumer accepts the result.
REQ-009 The block SHALL have port period  output  WIDTH  the rise-to-rise time.
REQ-010 The block SHALL have port highTime  output  WIDTH  the rise-to-fall time.
REQ-011 The block SHALL have port flags  output  3  sticky {stuck, overrun, glitch}.
REQ-012 The block SHALL have port clrFlags  input  1  a one-cycle pulse that clears flags.

Function
REQ-013 Edge detection SHALL operate on the N+1-bit word {pinD, prevMsb}, where prevMsb is the registered pinD[N-1] from the previous cycle.
- A rise at index k SHALL mean bit k-1 = 0 and bit k = 1.
- A fall at index k SHALL mean bit k-1 = 1 and bit k = 0.
REQ-014 The timestamp of an edge at index k SHALL be {tb, k[HRBITS-1:0]}.
REQ-015 The FSM SHALL have the states IDLE, HIGH and LOW.
- IDLE -> HIGH on a rise: store R = rise timestamp.
- HIGH -> LOW on a fall: store F.
- LOW -> HIGH on a rise R2: emit period = R2-R and highTime = F-R, then set R = R2.
REQ-016 Per word, the FSM SHALL consume the first edge qualifying for the current state, then the first opposite edge strictly after it in the same word; both transitions SHALL apply in one cycle.
- Example: in LOW, pinD = 0011_1000 gives a rise at 3 and a fall at 6, and the FSM ends in LOW.
REQ-017 Any further edges in a word SHALL be ignored and SHALL set the glitch flag.
REQ-018 All differences SHALL be computed modulo 2^WIDTH, so tb wrap-around is transparent.
REQ-019 Results SHALL be registered: capValid rises in the cycle after the clk edge that samples the word containing R2.
REQ-020 A valid/ready handshake SHALL apply.
- A result SHALL be held stable while capValid && !capReady.
- capValid SHALL drop after a cycle with capValid && capReady, unless a new result loads in that same cycle, in which case capValid stays high with the new data.
REQ-021 If a result completes while capValid && !capReady, the new result SHALL be dropped, the old result kept, and overrun set.
REQ-022 A stuck counter SHALL count cycles with no consumed edge.
- When it reaches 2^(WIDTH-HRBITS)-1, the block SHALL set stuck, go to IDLE and restart the count.
- The stuck condition SHALL cause no result.
REQ-023 The first period after IDLE SHALL need a full rise-fall-rise sequence; no partial result SHALL ever be emitted.
REQ-024 When clrFlags and a flag-set event occur in the same cycle, set SHALL win.

Reset
REQ-025 On rst the block SHALL set state = IDLE and prevMsb = 1, so that an all-ones idle line gives no false rise.
REQ-026 On rst the block SHALL clear capValid, period, highTime, flags, R, F and the stuck counter to 0.
REQ-027 An rst mid-measurement SHALL discard the partial state; the outputs SHALL take their reset values asynchronously.

Structure
REQ-028 Package pwm_pkg SHALL hold:
- default WIDTH and HRBITS;
- the state enum typedef (IDLE/HIGH/LOW);
- a packed capture-result struct {period, highTime}.
REQ-029 Sub-module hr_edge_find SHALL be combinational.
- Inputs: the N+1-bit word, edge polarity, start index.
- Outputs: found, index.
- It SHALL be instantiated twice: first edge and follow-on opposite edge.

Verification (WIDTH=17, HRBITS=3)
REQ-030 Basic measurement SHALL be covered.
- Stimulus: tb=2, pinD=1111_1000; then tb=10, pinD=0000_0111; then tb=42, pinD=1111_1100.
- Response: period=319, highTime=64, capValid 1 cycle after tb=42.
REQ-031 Wrap-around SHALL be covered.
- Stimulus: rise ts 0x1FFF0, fall ts 0x1FFF8, next rise ts 0x00010.
- Response: period=0x20, highTime=8.
REQ-032 A narrow pulse SHALL be covered.
- Stimulus: in LOW with R=0, word tb=5, pinD=0011_1000.
- Response: the state stays LOW; the next rise yields highTime=3.
REQ-033 Glitch SHALL be covered.
- Stimulus: in LOW, pinD=0101_0100.
- Response: rise at 2 and fall at 3 consumed; glitch=1; clrFlags clears it.
REQ-034 Overrun SHALL be covered.
- Stimulus: capReady=0 across two complete periods.
- Response: overrun=1, first result retained; capReady=1 then drops capValid.
REQ-035 Stuck and reset SHALL be covered.
- Stimulus: a constant pinD for 16383 cycles.
- Response: stuck=1, state IDLE.
- Stimulus: rst asserted in HIGH.
- Response: all outputs 0 immediately.
